// File: rtl/multi_port_ram_pkg.sv
// Shared types and constants for the multi-port register-file RAM.
// Optional feature macro: MULTI_PORT_RAM_COLL_CNT_EN (collision counter).
package multi_port_ram_pkg;

   typedef enum logic [0:0] {
      MPR_CLR = 1'b0,
      MPR_RUN = 1'b1
   } mpr_state_e;

   localparam int COLL_CNT_W = 16;
   localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = 16'hFFFF;

   // Wide enough for the loser popcount of up to eight ports.
   localparam int LOSE_CNT_W = 4;

endpackage

// File: rtl/multi_port_ram_if.sv
// Port bundle of the multi-port RAM: clear handshake plus per-port buses.
// Optional feature macro: MULTI_PORT_RAM_COLL_CNT_EN (drives coll_count).
interface multi_port_ram_if
   import multi_port_ram_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 48,
   parameter int NPORTS = 4,
   parameter int AW     = $clog2(DEPTH)
);

   logic                    clear;
   logic                    ready;
   logic [NPORTS-1:0]       we;
   logic [NPORTS*AW-1:0]    addr;
   logic [NPORTS*WIDTH-1:0] data;
   logic [NPORTS*WIDTH-1:0] q;
   logic [NPORTS-1:0]       oob;
   logic [NPORTS-1:0]       collision;
   logic [COLL_CNT_W-1:0]   coll_count;

   modport master (
      output clear, we, addr, data,
      input  ready, q, oob, collision, coll_count
   );

   modport slave (
      input  clear, we, addr, data,
      output ready, q, oob, collision, coll_count
   );

endinterface

// File: rtl/multi_port_ram_arbiter.sv
// Combinational write arbiter: among enabled, in-range writers the lowest
// port index wins each address; every other writer to that address loses.
module multi_port_ram_arbiter
   import multi_port_ram_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int AW     = 6
) (
   input  logic [NPORTS-1:0]     we,
   input  logic [NPORTS*AW-1:0]  addr,
   input  logic [NPORTS-1:0]     in_range,
   output logic [NPORTS-1:0]     grant,
   output logic [NPORTS-1:0]     lose,
   output logic [LOSE_CNT_W-1:0] lose_cnt
);

   logic [NPORTS-1:0] en;
   logic [NPORTS-1:0] blocked;

   // A writer is blocked when any lower-indexed enabled writer hits its address
   always_comb begin
      en       = we & in_range;
      blocked  = '0;
      grant    = '0;
      lose     = '0;
      lose_cnt = '0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int j = 0; j < p; j++) begin
            if (en[j] && (addr[j*AW +: AW] == addr[p*AW +: AW])) begin
               blocked[p] = 1'b1;
            end
         end
         grant[p] = en[p] & ~blocked[p];
         lose[p]  = en[p] &  blocked[p];
         lose_cnt = lose_cnt + LOSE_CNT_W'(lose[p]);
      end
   end

endmodule

// File: rtl/multi_port_ram.sv
// N-port register-file RAM with read-first registered reads, priority write
// collision resolution, out-of-range protection and a zeroing sequencer.
// Optional feature macro: MULTI_PORT_RAM_COLL_CNT_EN builds the saturating
// dropped-write counter; otherwise coll_count is tied to zero.
module multi_port_ram
   import multi_port_ram_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 48,
   parameter  int NPORTS = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   multi_port_ram_if.slave  bus
);

   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [WIDTH-1:0]        ram [DEPTH];
   mpr_state_e              state;
   logic [AW-1:0]           clr_ptr;
   logic                    clr_pend;
   logic                    run;
   logic [AW-1:0]           port_addr [NPORTS];
   logic [WIDTH-1:0]        port_data [NPORTS];
   logic [NPORTS-1:0]       in_range;
   logic [NPORTS-1:0]       live;
   logic [NPORTS-1:0]       grant;
   logic [NPORTS-1:0]       lose;
   logic [LOSE_CNT_W-1:0]   lose_cnt;
   logic [NPORTS*WIDTH-1:0] q_p1;
   logic [NPORTS-1:0]       oob_p1;
   logic [NPORTS-1:0]       coll_p1;

   assign run = (state == MPR_RUN);

   // Split the packed buses per port and flag addresses inside the array
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         port_addr[p] = bus.addr[p*AW +: AW];
         port_data[p] = bus.data[p*WIDTH +: WIDTH];
         in_range[p]  = ({1'b0, port_addr[p]} < DEPTH_EXT);
      end
   end

   // Ports only take part in arbitration while the array is in normal use
   assign live = in_range & {NPORTS{run}};

   multi_port_ram_arbiter #(
      .NPORTS (NPORTS),
      .AW     (AW)
   ) u_arbiter (
      .we       (bus.we),
      .addr     (bus.addr),
      .in_range (live),
      .grant    (grant),
      .lose     (lose),
      .lose_cnt (lose_cnt)
   );

   // Clear sequencer: a clear request is latched in RUN and takes effect on
   // the following edge, then DEPTH cycles zero the array one word at a time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MPR_CLR;
         clr_ptr  <= '0;
         clr_pend <= 1'b0;
      end else begin
         case (state)
            MPR_CLR: begin
               if (clr_ptr == LAST_ADDR) begin
                  state   <= MPR_RUN;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + 1'b1;
               end
            end
            default: begin
               if (clr_pend) begin
                  state    <= MPR_CLR;
                  clr_pend <= 1'b0;
               end else if (bus.clear) begin
                  clr_pend <= 1'b1;
               end
            end
         endcase
      end
   end

   // Array update: the sequencer owns the array while clearing, otherwise
   // each granted port writes (granted addresses are always distinct)
   always_ff @(posedge clk) begin
      if (state == MPR_CLR) begin
         ram[clr_ptr] <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            if (grant[p]) begin
               ram[port_addr[p]] <= port_data[p];
            end
         end
      end
   end

   // Read stage: read-first data and per-cycle flags, all forced low while clearing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_p1    <= '0;
         oob_p1  <= '0;
         coll_p1 <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            q_p1[p*WIDTH +: WIDTH] <= live[p] ? ram[port_addr[p]] : '0;
            oob_p1[p]              <= run & ~in_range[p];
         end
         coll_p1 <= lose;
      end
   end

   assign bus.q         = q_p1;
   assign bus.oob       = oob_p1;
   assign bus.collision = coll_p1;
   assign bus.ready     = run;

`ifdef MULTI_PORT_RAM_COLL_CNT_EN
   logic [COLL_CNT_W-1:0] coll_cnt;

   function automatic logic [COLL_CNT_W-1:0] sat_add(
      input logic [COLL_CNT_W-1:0] cnt,
      input logic [LOSE_CNT_W-1:0] inc
   );
      logic [COLL_CNT_W:0] sum;
      sum = {1'b0, cnt} + (COLL_CNT_W+1)'(inc);
      return sum[COLL_CNT_W] ? COLL_CNT_MAX : sum[COLL_CNT_W-1:0];
   endfunction

   // Dropped-write counter: zeroed when a clear starts, saturates at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_cnt <= '0;
      end else if (run && clr_pend) begin
         coll_cnt <= '0;
      end else if (lose_cnt != '0) begin
         coll_cnt <= sat_add(coll_cnt, lose_cnt);
      end
   end

   assign bus.coll_count = coll_cnt;
`else
   logic [LOSE_CNT_W-1:0] unused_lose_cnt;
   assign unused_lose_cnt = lose_cnt;
   assign bus.coll_count  = '0;
`endif

endmodule

// File: tb/tb_multi_port_ram.sv
// Self-checking bench for multi_port_ram (default parameters).
// Honours MULTI_PORT_RAM_COLL_CNT_EN for the expected coll_count.
module tb_multi_port_ram;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 48;
   localparam int NPORTS = 4;
   localparam int AW     = 6;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multi_port_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS)) bus ();

   multi_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [NPORTS*WIDTH-1:0] q;
      logic [NPORTS-1:0]       oob;
      logic [NPORTS-1:0]       coll;
      logic [15:0]             cc;
   } exp_t;

   exp_t             sbq [$];
   logic [WIDTH-1:0] mem [DEPTH];
   int               exp_cc;
   int               checks = 0;
   int               errors = 0;

   logic [NPORTS-1:0] twe;
   logic [AW-1:0]     taddr [NPORTS];
   logic [WIDTH-1:0]  tdata [NPORTS];

   task automatic set_idle();
      twe = '0;
      for (int p = 0; p < NPORTS; p++) begin
         taddr[p] = '0;
         tdata[p] = '0;
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      exp_cc = 0;
   endtask

   // Drive one access cycle from twe/taddr/tdata, queue the expected outputs
   // for after the edge, then apply the writes to the model (read-first).
   task automatic do_cycle(input logic clr);
      exp_t              e;
      logic [NPORTS-1:0] inr;
      logic [NPORTS-1:0] en;
      int                lcnt;
      lcnt = 0;
      for (int p = 0; p < NPORTS; p++) begin
         inr[p] = (int'(taddr[p]) < DEPTH);
         en[p]  = twe[p] & inr[p];
      end
      for (int p = 0; p < NPORTS; p++) begin
         e.q[p*WIDTH +: WIDTH] = inr[p] ? mem[taddr[p]] : '0;
         e.oob[p]  = ~inr[p];
         e.coll[p] = 1'b0;
         for (int j = 0; j < p; j++)
            if (en[p] && en[j] && taddr[j] == taddr[p]) e.coll[p] = 1'b1;
         if (e.coll[p]) lcnt++;
      end
`ifdef MULTI_PORT_RAM_COLL_CNT_EN
      exp_cc = (exp_cc + lcnt > 65535) ? 65535 : exp_cc + lcnt;
`endif
      e.cc = 16'(exp_cc);
      bus.we    = twe;
      bus.clear = clr;
      for (int p = 0; p < NPORTS; p++) begin
         bus.addr[p*AW +: AW]       = taddr[p];
         bus.data[p*WIDTH +: WIDTH] = tdata[p];
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
      for (int p = NPORTS - 1; p >= 0; p--)
         if (en[p]) mem[taddr[p]] = tdata[p];
      bus.clear = 1'b0;
      bus.we    = '0;
   endtask

   // Setup only: write a distinct nonzero word into every address
   task automatic fill_all();
      for (int c = 0; c < DEPTH / NPORTS; c++) begin
         twe = '1;
         for (int p = 0; p < NPORTS; p++) begin
            taddr[p] = AW'(c * NPORTS + p);
            tdata[p] = 32'hC0DE_0000 + 32'(c * NPORTS + p + 1);
         end
         do_cycle(1'b0);
      end
      sbq.delete();
      set_idle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.clear = 1'b0; bus.we = '0; bus.addr = '0; bus.data = '0;
      set_idle();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.ready !== 1'b0 || bus.q !== '0 || bus.oob !== '0 || bus.collision !== '0 || bus.coll_count !== '0) begin
         errors++;
         $display("FAIL reset_values ready=%b q=%h oob=%b coll=%b cc=%0d required all zero",
                  bus.ready, bus.q, bus.oob, bus.collision, bus.coll_count);
      end
      rst_n = 1'b1;
      model_clear();
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.ready !== (i == DEPTH)) begin
            errors++;
            $display("FAIL reset_ready edge %0d ready=%b required %b", i, bus.ready, (i == DEPTH));
         end
      end
      for (int c = 0; c < DEPTH / NPORTS; c++) begin
         exp_t e;
         for (int p = 0; p < NPORTS; p++) taddr[p] = AW'(c * NPORTS + p);
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.q !== '0 || bus.oob !== e.oob || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_readback cyc %0d q=%h oob=%b ready=%b required q=%h oob=%b ready=1",
                     c, bus.q, bus.oob, bus.ready, e.q, e.oob);
         end
      end
   endtask

   task automatic test_read_first();
      for (int c = 0; c < 2; c++) begin
         exp_t e;
         set_idle();
         taddr[3] = 6'd5;
         if (c == 0) begin
            twe = 4'b0010; taddr[1] = 6'd5; tdata[1] = 32'hDEADBEEF;
         end
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.oob !== e.oob || bus.collision !== e.coll || bus.coll_count !== e.cc) begin
            errors++;
            $display("FAIL read_first cyc %0d q=%h oob=%b coll=%b cc=%0d required q=%h oob=%b coll=%b cc=%0d",
                     c, bus.q, bus.oob, bus.collision, bus.coll_count, e.q, e.oob, e.coll, e.cc);
         end
         checks++;
         if (bus.q[3*WIDTH +: WIDTH] !== ((c == 0) ? 32'h0 : 32'hDEADBEEF)) begin
            errors++;
            $display("FAIL read_first_port3 cyc %0d q3=%h required %h", c,
                     bus.q[3*WIDTH +: WIDTH], (c == 0) ? 32'h0 : 32'hDEADBEEF);
         end
      end
   endtask

   task automatic test_collision();
      for (int c = 0; c < 2; c++) begin
         exp_t e;
         set_idle();
         for (int p = 0; p < NPORTS; p++) taddr[p] = 6'd7;
         if (c == 0) begin
            twe = 4'b1101; tdata[0] = 32'h11; tdata[2] = 32'h22; tdata[3] = 32'h33;
         end
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.oob !== e.oob || bus.collision !== e.coll || bus.coll_count !== e.cc) begin
            errors++;
            $display("FAIL collision cyc %0d q=%h oob=%b coll=%b cc=%0d required q=%h oob=%b coll=%b cc=%0d",
                     c, bus.q, bus.oob, bus.collision, bus.coll_count, e.q, e.oob, e.coll, e.cc);
         end
         if (c == 0) begin
            checks++;
`ifdef MULTI_PORT_RAM_COLL_CNT_EN
            if (bus.collision !== 4'b1100 || bus.coll_count !== 16'd2) begin
`else
            if (bus.collision !== 4'b1100 || bus.coll_count !== 16'd0) begin
`endif
               errors++;
               $display("FAIL collision_flags coll=%b cc=%0d required coll=1100 and spec count",
                        bus.collision, bus.coll_count);
            end
         end else begin
            checks++;
            if (bus.q[0 +: WIDTH] !== 32'h11 || bus.collision !== 4'b0000) begin
               errors++;
               $display("FAIL collision_winner q0=%h coll=%b required q0=00000011 coll=0000",
                        bus.q[0 +: WIDTH], bus.collision);
            end
         end
      end
   endtask

   task automatic test_oob();
      for (int c = 0; c < 3; c++) begin
         exp_t e;
         set_idle();
         case (c)
            0: begin
               twe = 4'b0100; taddr[2] = 6'd50; tdata[2] = 32'hAA;
               taddr[0] = 6'd47; taddr[1] = 6'd2; taddr[3] = 6'd5;
            end
            1: begin
               twe = 4'b0011; taddr[0] = 6'd48; taddr[1] = 6'd48;
               tdata[0] = 32'h1; tdata[1] = 32'h2; taddr[2] = 6'd47; taddr[3] = 6'd63;
            end
            default: begin
               taddr[0] = 6'd2; taddr[1] = 6'd18; taddr[2] = 6'd0; taddr[3] = 6'd47;
            end
         endcase
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.oob !== e.oob || bus.collision !== e.coll || bus.coll_count !== e.cc) begin
            errors++;
            $display("FAIL oob cyc %0d q=%h oob=%b coll=%b cc=%0d required q=%h oob=%b coll=%b cc=%0d",
                     c, bus.q, bus.oob, bus.collision, bus.coll_count, e.q, e.oob, e.coll, e.cc);
         end
         if (c == 0) begin
            checks++;
            if (bus.oob !== 4'b0100 || bus.q[2*WIDTH +: WIDTH] !== 32'h0 || bus.collision !== 4'b0000) begin
               errors++;
               $display("FAIL oob_port2 oob=%b q2=%h coll=%b required 0100 0 0000",
                        bus.oob, bus.q[2*WIDTH +: WIDTH], bus.collision);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 200; c++) begin
         exp_t e;
         twe = NPORTS'($urandom);
         for (int p = 0; p < NPORTS; p++) begin
            int a;
            a = int'($urandom_range(0, 15));
            taddr[p] = (a < 12) ? AW'(a % 6) : AW'(44 + (a - 12) * 3);
            tdata[p] = $urandom;
         end
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.oob !== e.oob || bus.collision !== e.coll || bus.coll_count !== e.cc) begin
            errors++;
            $display("FAIL back_to_back cyc %0d q=%h oob=%b coll=%b cc=%0d required q=%h oob=%b coll=%b cc=%0d",
                     c, bus.q, bus.oob, bus.collision, bus.coll_count, e.q, e.oob, e.coll, e.cc);
         end
      end
      set_idle();
   endtask

   task automatic test_clear();
      exp_t e;
      fill_all();
      do_cycle(1'b1);
      e = sbq.pop_front();
      checks++;
      if (bus.ready !== 1'b1 || bus.q !== e.q || bus.coll_count !== e.cc) begin
         errors++;
         $display("FAIL clear_request ready=%b q=%h cc=%0d required ready=1 q=%h cc=%0d",
                  bus.ready, bus.q, bus.coll_count, e.q, e.cc);
      end
      model_clear();
      for (int i = 1; i <= DEPTH; i++) begin
         bus.we = '0; bus.clear = (i == 10);
         if (i >= 2) begin
            bus.we   = '1;
            bus.addr = {6'd10, 6'd50, 6'd3, 6'd3};
            bus.data = {4{32'hFFFF_FFFF}};
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.ready !== 1'b0 || bus.coll_count !== '0 ||
             (i >= 2 && (bus.q !== '0 || bus.oob !== '0 || bus.collision !== '0))) begin
            errors++;
            $display("FAIL clear_window edge %0d ready=%b q=%h oob=%b coll=%b cc=%0d required ready=0 zeros",
                     i, bus.ready, bus.q, bus.oob, bus.collision, bus.coll_count);
         end
      end
      bus.we = '0; bus.clear = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_done ready=%b required 1", bus.ready);
      end
      for (int c = 0; c < DEPTH / NPORTS; c++) begin
         for (int p = 0; p < NPORTS; p++) taddr[p] = AW'(c * NPORTS + p);
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.q !== '0 || bus.coll_count !== e.cc || bus.coll_count !== '0) begin
            errors++;
            $display("FAIL clear_readback cyc %0d q=%h cc=%0d required q=0 cc=0", c, bus.q, bus.coll_count);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      fill_all();
      twe = 4'b0011; taddr[0] = 6'd2; taddr[1] = 6'd2; tdata[0] = 32'h5; tdata[1] = 32'h6;
      do_cycle(1'b0);
      set_idle();
      for (int p = 0; p < NPORTS; p++) taddr[p] = AW'(p + 1);
      do_cycle(1'b0);
      sbq.delete();
      rst_n = 1'b0;
      #2;
      checks++;
      if (bus.ready !== 1'b0 || bus.q !== '0 || bus.oob !== '0 || bus.collision !== '0 || bus.coll_count !== '0) begin
         errors++;
         $display("FAIL reset_mid_run ready=%b q=%h oob=%b coll=%b cc=%0d required all zero",
                  bus.ready, bus.q, bus.oob, bus.collision, bus.coll_count);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      repeat (DEPTH) @(posedge clk);
      #1;
      fill_all();
      do_cycle(1'b1);
      sbq.delete();
      model_clear();
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_clear_state ready=%b required 0", bus.ready);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (bus.ready !== 1'b0 || bus.q !== '0 || bus.coll_count !== '0) begin
         errors++;
         $display("FAIL reset_mid_clear ready=%b q=%h cc=%0d required zeros", bus.ready, bus.q, bus.coll_count);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.ready !== (i == DEPTH)) begin
            errors++;
            $display("FAIL restart_ready edge %0d ready=%b required %b", i, bus.ready, (i == DEPTH));
         end
      end
      for (int c = 0; c < DEPTH / NPORTS; c++) begin
         for (int p = 0; p < NPORTS; p++) taddr[p] = AW'(c * NPORTS + p);
         do_cycle(1'b0);
         e = sbq.pop_front();
         checks++;
         if (bus.q !== e.q || bus.q !== '0) begin
            errors++;
            $display("FAIL restart_readback cyc %0d q=%h required %h", c, bus.q, e.q);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_first();
      test_collision();
      test_oob();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_port_ram.md
# multi_port_ram

Parametrised N-port register-file RAM, the successor to the fixed four-port buffer used for the weight and input stores. Each port has independent address, write enable, data and a registered read output. New over the previous generation:
- deterministic write-collision resolution with per-port collision flags;
- out-of-range address protection;
- a built-in clear sequencer that zeroes the array after reset or on request.

## Interface
- `WIDTH`, 32, data word width in bits (≥1)
- `DEPTH`, 48, number of words (≥2; need not be a power of two)
- `NPORTS`, 4, number of read/write ports (1..8)
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  single-cycle request to re-zero the array; honoured only when `ready`=1
- `ready`  out  1  array usable; 0 while clearing
- `we`  in  NPORTS  per-port write enable
- `addr`  in  NPORTS×AW  per-port address, port p at bits [p*AW +: AW]
- `data`  in  NPORTS×WIDTH  per-port write data
- `q`  out  NPORTS×WIDTH  per-port registered read data
- `oob`  out  NPORTS  per-port registered flag: last cycle's address ≥ DEPTH
- `collision`  out  NPORTS  per-port registered flag: last cycle's write was dropped for collision
- `coll_count`  out  16  saturating count of dropped writes (see Configuration)

## Operation
- FSM states:
  - CLR: counter `clr_ptr` writes 0 to `ram[clr_ptr]` each cycle, 0..DEPTH-1. At DEPTH-1 the FSM goes to RUN.
  - RUN: normal port access.
- Reset enters CLR with `clr_ptr`=0. `clear`=1 in RUN enters CLR next cycle. `clear` in CLR is ignored, with no restart.
- In CLR: all port writes are ignored, `q`=0, and the `oob`/`collision` flags are 0.
- Writes in RUN: port p writes `data[p]` to `ram[addr[p]]` when `we[p]`=1 and `addr[p]` < DEPTH.
- Collision: two or more enabled in-range ports target the same address in one cycle. The lowest port index wins. Each losing port gets `collision[p]`=1 next cycle, and `coll_count` increments by the number of losers (saturates at 16'hFFFF).
- Reads are read-first: `q[p]` next cycle equals the array content before this cycle's writes. Same-cycle write data is not forwarded.
- Out of range (`addr[p]` ≥ DEPTH): any write is dropped, `q[p]`=0 next cycle, `oob[p]`=1 next cycle. An out-of-range write never counts as a collision.
- Addresses are compared only among enabled, in-range writers. Reads never cause collisions.

## Timing
- Reset values: `ready`=0, `q`=0, `oob`=0, `collision`=0, `coll_count`=0, FSM=CLR, `clr_ptr`=0.
- Read latency is 1 cycle: `addr` sampled at edge k, `q` valid after edge k.
- Write latency is 1 cycle: a write at edge k is visible to a read sampled at edge k+1.
- Clear duration is exactly DEPTH cycles.
  - After reset release, `ready` rises after the DEPTH-th edge.
  - From `clear` sampled at edge k, `ready`=0 from edge k+1 to edge k+DEPTH, and `ready`=1 after edge k+DEPTH+1.
- Reset asserted mid-clear or mid-run: all outputs return to reset values immediately. The clear restarts from address 0 after release.
- Flags are per-cycle: they are 1 only for the cycle after the event and are not sticky. `coll_count` is sticky until reset or `clear`, which zeroes it on entering CLR.

## Configuration
- `MULTI_PORT_RAM_COLL_CNT_EN`:
  - Defined: the `coll_count` counter is built as specified.
  - Undefined: the counter logic is removed and `coll_count` is tied to 0. The per-port `collision` flags and priority resolution remain.

## Structure
- Package `multi_port_ram_pkg`: FSM state enum (`MPR_CLR`, `MPR_RUN`), the `COLL_CNT_W`=16 constant and the saturation max constant.
- Sub-module `multi_port_ram_arbiter`, purely combinational:
  - inputs: `we`, `addr`, in-range mask;
  - outputs: per-port `grant` and `lose` vectors, plus the loser popcount.
- The top holds the array, FSM, read registers and counter.

## Test plan
- Reset release, DEPTH=48: `ready`=0 for 48 cycles, then 1. All addresses read back 0.
- Port 1 writes 0xDEADBEEF to addr 5 while port 3 reads addr 5 in the same cycle. Port 3 `q` is the old value 0. A read next cycle returns 0xDEADBEEF.
- Ports 0, 2 and 3 write 0x11, 0x22 and 0x33 to addr 7 in one cycle. addr 7 = 0x11, `collision`=4'b1100, `coll_count`=2. With the macro undefined, `coll_count` stays 0.
- Port 2 addr=50 with `we`=1, data 0xAA: the array is unchanged, `q[2]`=0, `oob`=4'b0100, `collision`=0.
- Fill addr 0..47 with nonzero data, pulse `clear`: `ready`=0 for 48 cycles, writes during that window are ignored, all words read 0 afterwards, `coll_count`=0.
- Assert `rst_n` low at clear cycle 20, release: the sequencer restarts, `ready` returns after 48 full cycles, and all words read 0.
